// File: rtl/booth_pp_gen_pipe.sv
// booth_pp_gen_pipe
// Radix-4 Booth partial-product generator with a segmented, pipelined
// negation chain. A DATA_W-bit signed multiplicand X and a Booth code
// select one of {0, +X, -X, +2X, -2X}, produced exactly at DATA_W+2 bits.
//
// Negation is done with the OR-chain form of invert-plus-one:
//   out[i] = v[i] XOR OR(v[i-1:0])
// The chain is cut into PIPE_STG segments. Stage k resolves segment k using
// the OR-carry handed over by stage k-1, so the critical path is one segment
// long. Bits above the current segment travel unresolved in the stage word.
//
// Flow control is a simple valid/ready pipeline. Every stage moves when it
// is empty or when the stage after it moves; the last stage moves on
// out_ready. in_ready is therefore combinational from out_ready.
module booth_pp_gen_pipe #(
  parameter int DATA_W   = 16,
  parameter int PIPE_STG = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  input  logic [2:0]        sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W+1:0] pp,
  output logic              pp_neg
);

  // Full result width and segment length of the negation chain.
  localparam int W2  = DATA_W + 2;
  localparam int SEG = (W2 + PIPE_STG - 1) / PIPE_STG;
  // Carries are only handed between stages, so there are PIPE_STG-1 of them;
  // keep at least one bit so the vector stays legal for PIPE_STG = 1.
  localparam int CW  = (PIPE_STG > 1) ? (PIPE_STG - 1) : 1;

  // Resolve segment k of word: inside the segment every bit is flipped when
  // the multiple is negative and some lower bit of v is set. Bits outside the
  // segment pass through untouched.
  function automatic logic [W2-1:0] seg_resolve(
    input logic [W2-1:0] word,
    input logic          neg,
    input logic          cin,
    input int            k
  );
    logic [W2-1:0] res;
    logic          c;
    res = word;
    c   = cin;
    for (int i = 0; i < W2; i++) begin
      if ((i >= k * SEG) && (i < (k + 1) * SEG)) begin
        res[i] = word[i] ^ (neg & c);
        c      = c | word[i];
      end else begin
        res[i] = word[i];
      end
    end
    return res;
  endfunction

  // OR-carry leaving segment k: set when any bit of v at or below the top of
  // the segment is set.
  function automatic logic seg_carry(
    input logic [W2-1:0] word,
    input logic          cin,
    input int            k
  );
    logic c;
    c = cin;
    for (int i = 0; i < W2; i++) begin
      if ((i >= k * SEG) && (i < (k + 1) * SEG)) begin
        c = c | word[i];
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Booth decode signals
  logic [W2-1:0] x_ext_s;
  logic [W2-1:0] x_dbl_s;
  logic [W2-1:0] v_in_s;
  logic          neg_in_s;

  // Pipeline state: the word holds resolved low bits and unresolved high bits
  logic [W2-1:0]       data_r [PIPE_STG];
  logic [PIPE_STG-1:0] valid_r;
  logic [PIPE_STG-1:0] neg_r;
  logic [CW-1:0]       carry_r;

  // Per-stage resolved words, carries and advance enables
  logic [W2-1:0] res_s [PIPE_STG];
  logic [CW-1:0] cout_s;
  logic [PIPE_STG:0] adv_s;

  // Booth decode: pick v in {0, X, 2X} sign-extended and the negate flag.
  always_comb begin
    x_ext_s  = {{2{din[DATA_W-1]}}, din};
    x_dbl_s  = {din[DATA_W-1], din, 1'b0};
    v_in_s   = {W2{1'b0}};
    neg_in_s = 1'b0;
    case (sel)
      3'b001, 3'b010: begin
        v_in_s   = x_ext_s;
        neg_in_s = 1'b0;
      end
      3'b011: begin
        v_in_s   = x_dbl_s;
        neg_in_s = 1'b0;
      end
      3'b100: begin
        v_in_s   = x_dbl_s;
        neg_in_s = 1'b1;
      end
      3'b101, 3'b110: begin
        v_in_s   = x_ext_s;
        neg_in_s = 1'b1;
      end
      default: begin
        // 000 and 111 select zero; v = 0 keeps the chain inert.
        v_in_s   = {W2{1'b0}};
        neg_in_s = 1'b0;
      end
    endcase
  end

  // Segment resolution: stage 0 works on the decoded input, later stages on
  // the word registered by the stage before them.
  always_comb begin
    res_s[0] = seg_resolve(v_in_s, neg_in_s, 1'b0, 0);
    for (int k = 1; k < PIPE_STG; k++) begin
      res_s[k] = seg_resolve(data_r[k-1], neg_r[k-1], carry_r[k-1], k);
    end
  end

  // OR-carry generation for every stage that hands a carry forward.
  always_comb begin
    cout_s    = {CW{1'b0}};
    cout_s[0] = seg_carry(v_in_s, 1'b0, 0);
    for (int k = 1; k < PIPE_STG - 1; k++) begin
      cout_s[k] = seg_carry(data_r[k-1], carry_r[k-1], k);
    end
  end

  // Advance enables in closed form: stage k moves if it or any later stage is
  // empty, or the consumer takes the output.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    adv_s = {(PIPE_STG + 1){1'b0}};
    for (int k = 0; k <= PIPE_STG; k++) begin
      acc = out_ready;
      for (int j = k; j < PIPE_STG; j++) begin
        acc = acc | ~valid_r[j];
      end
      adv_s[k] = acc;
    end
  end

  // Pipeline registers: bubbles clear the valid bit but leave data untouched.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_r <= {PIPE_STG{1'b0}};
      neg_r   <= {PIPE_STG{1'b0}};
      carry_r <= {CW{1'b0}};
      for (int k = 0; k < PIPE_STG; k++) begin
        data_r[k] <= {W2{1'b0}};
      end
    end else begin
      if (adv_s[0]) begin
        valid_r[0] <= in_valid;
        if (in_valid) begin
          data_r[0]  <= res_s[0];
          neg_r[0]   <= neg_in_s;
          carry_r[0] <= cout_s[0];
        end
      end
      for (int k = 1; k < PIPE_STG; k++) begin
        if (adv_s[k]) begin
          valid_r[k] <= valid_r[k-1];
          if (valid_r[k-1]) begin
            data_r[k] <= res_s[k];
            neg_r[k]  <= neg_r[k-1];
          end
        end
      end
      for (int k = 1; k < PIPE_STG - 1; k++) begin
        if (adv_s[k] && valid_r[k-1]) begin
          carry_r[k] <= cout_s[k];
        end
      end
    end
  end

  // Outputs come straight from the last stage registers.
  assign in_ready  = adv_s[0];
  assign out_valid = valid_r[PIPE_STG-1];
  assign pp        = data_r[PIPE_STG-1];
  assign pp_neg    = neg_r[PIPE_STG-1];

endmodule
